uart_stream_tx: RTL and testbench
=================================

# uart_stream_tx

Parametrised, buffered UART transmitter: the successor to the fixed-byte, single-shot FTDI transmit path. A FIFO decouples producers such as the ALS sampler or a debug counter from the serial line. The block drains that FIFO back-to-back, gates each new frame with a clear-to-send input, and reports overflow. It sits between on-chip data sources and the FTDI_RX pin.

## Interface
- `FREQUENCY`, 50_000_000: clk frequency in Hz.
- `BAUD_RATE`, 115_200: line rate; divisor `DIV = FREQUENCY / BAUD_RATE` (integer truncation, must be ≥ 2).
- `DATA_BITS`, 8: payload width, 5..9.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 16: entries, power of two, ≥ 2.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `data` in DATA_BITS: word to enqueue.
- `write` in 1: enqueue strobe, one word per cycle.
- `cts` in 1: clear-to-send, active-high, already synchronous to clk.
- `tx` out 1: serial line; idle high.
- `full` out 1: FIFO holds FIFO_DEPTH words.
- `empty` out 1: FIFO holds 0 words.
- `level` out $clog2(FIFO_DEPTH)+1: current occupancy.
- `busy` out 1: frame in progress (state ≠ IDLE).
- `overflow` out 1: sticky; set by a write while full.
- `baud_tick` out 1: one-cycle pulse at the end of each bit period.

## Operation
- Reset values: tx=1, full=0, empty=1, level=0, busy=0, overflow=0, baud_tick=0, state=IDLE, divider=0.
- FIFO write:
  - Accepted iff `write && !full` in that cycle.
  - A rejected write leaves the FIFO unchanged and sets `overflow`. Only reset clears `overflow`.
- FIFO pop occurs only on the IDLE→START transition.
- Write and pop in the same cycle:
  - Not full: level is unchanged.
  - Full: the write is rejected, even though a pop happens.
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
  - IDLE: tx=1. If `!empty && cts`, pop the head into the shift register, clear the divider and the bit counter, and go to START.
  - START: tx=0 for one bit period, then DATA.
  - DATA: tx = shift register bit 0, LSB first. Shift on each tick. After DATA_BITS ticks, go to PARITY if enabled, otherwise STOP.
  - PARITY: tx = parity bit for one bit period, then STOP.
  - STOP: tx=1 for STOP_BITS bit periods, then IDLE.
- `cts` is examined only in IDLE. Deasserting it mid-frame never truncates a frame.
- Divider:
  - Counts 0..DIV-1 while busy and holds 0 in IDLE.
  - `baud_tick` is high in the cycle the counter equals DIV-1.
  - Each bit lasts exactly DIV cycles.
- Reset mid-frame: tx returns high immediately (asynchronously), the FIFO is emptied, and the partial frame is abandoned.

## Timing
- `tx` is registered. There is no combinational path from any input to `tx`.
- Latency: write at cycle N into an empty FIFO with cts=1:
  - empty=0, level=1 at N+1.
  - IDLE→START transition at N+1.
  - tx falls at N+2.
- Frame length: (1 + DATA_BITS + P + STOP_BITS)·DIV cycles, where P=1 with parity and 0 without.
- Back-to-back: if the FIFO is non-empty and cts=1 when STOP ends, exactly one IDLE cycle (tx=1) separates the stop bit from the next start bit.
- `full`, `empty` and `level` are registered and reflect all writes and pops up to the previous edge.

## Configuration
- `UART_STREAM_PARITY_EN` defined:
  - Adds the PARITY state and a parameter `PARITY_ODD`, default 0.
  - The parity bit is even parity, XOR of the payload, or odd parity when PARITY_ODD=1.
  - Frames grow by one bit period.
- `UART_STREAM_PARITY_EN` undefined:
  - No parity logic, PARITY state or PARITY_ODD parameter.
  - DATA goes directly to STOP.

## Test plan
Common setup for all scenarios: FREQUENCY=1_000_000, BAUD_RATE=100_000 (DIV=10), DATA_BITS=8, STOP_BITS=1, FIFO_DEPTH=4, macro off unless stated.
- Single byte: write 0x4A with cts=1.
  - Response: tx low at N+2, then bits 0,1,0,1,0,0,1,0 at 10 cycles each, then stop high.
  - busy drops 100 cycles after tx falls.
- Back-to-back: write 0x55 and 0xAA on consecutive cycles.
  - Response: two frames separated by exactly one idle cycle; 10 baud_tick pulses per frame.
- Overflow with cts=0: write 5 words.
  - Response: level=4, full=1, overflow=1, tx stays high.
  - Then raise cts: 4 frames are sent in FIFO order; the 5th word is never sent.
- Flow control: drop cts during the 3rd data bit of a frame with one more word queued.
  - Response: the current frame completes.
  - The next start bit appears no earlier than the cycle after cts returns high.
- Reset mid-frame: assert reset during bit 4 of the frame.
  - Response: tx=1, level=0, empty=1, busy=0 immediately; no further tx activity.
- Parity (macro on, PARITY_ODD=0): write 0x07.
  - Response: parity bit is 1 and the frame is 110 cycles long.

Source files
------------

// File: rtl/uart_stream_tx.sv
// uart_stream_tx: buffered UART transmitter.
// A FIFO of FIFO_DEPTH words feeds a start/data/stop serialiser that drains
// it back-to-back, gated per frame by cts. Overflow is sticky until reset.
// Optional feature: define UART_STREAM_PARITY_EN to add a parity bit
// (even, or odd with PARITY_ODD=1).
module uart_stream_tx #(
    parameter int FREQUENCY  = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
`ifdef UART_STREAM_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_BITS-1:0]        data,
    input  logic                        write,
    input  logic                        cts,
    output logic                        tx,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        busy,
    output logic                        overflow,
    output logic                        baud_tick
);
    localparam int DIV = FREQUENCY / BAUD_RATE;
    localparam int DW  = $clog2(DIV);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_ONE   = DW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   LVL_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_STREAM_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                r_state;
    logic                  r_tx;
    logic [DW-1:0]         r_div;
    logic [BW-1:0]         r_bit;
    logic                  r_stop;
    logic [DATA_BITS-1:0]  r_shift;
`ifdef UART_STREAM_PARITY_EN
    logic                  r_par;
`endif

    logic [DATA_BITS-1:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_level;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_overflow;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_tick;
    logic [AW:0]           w_level_nxt;

    // A full FIFO rejects writes even when a pop happens in the same cycle.
    assign w_push = write && !r_full;
    assign w_pop  = (r_state == S_IDLE) && !r_empty && cts;
    assign w_tick = (r_state != S_IDLE) && (r_div == DIV_LAST);

    // Next occupancy from this cycle's push/pop pair.
    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop)
            w_level_nxt = r_level + LVL_ONE;
        else if (!w_push && w_pop)
            w_level_nxt = r_level - LVL_ONE;
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= data;
    end

    // FIFO pointers, registered status flags and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LVL_FULL);
            r_empty <= (w_level_nxt == '0);
            if (write && r_full)
                r_overflow <= 1'b1;
        end
    end

    // Frame FSM with bit divider; tx is registered and set one state ahead.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_div   <= '0;
            r_bit   <= '0;
            r_stop  <= 1'b0;
            r_shift <= '0;
`ifdef UART_STREAM_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            if (r_state != S_IDLE)
                r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_ONE;
            case (r_state)
                S_IDLE: begin
                    r_tx  <= 1'b1;
                    r_div <= '0;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_bit   <= '0;
                        r_stop  <= 1'b0;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
`ifdef UART_STREAM_PARITY_EN
                        r_par   <= (^r_mem[r_rd_ptr]) ^ PARITY_ODD;
`endif
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_shift <= r_shift >> 1;
                        if (r_bit == BIT_LAST) begin
`ifdef UART_STREAM_PARITY_EN
                            r_tx    <= r_par;
                            r_state <= S_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit <= r_bit + BIT_ONE;
                            r_tx  <= r_shift[1];
                        end
                    end
                end
`ifdef UART_STREAM_PARITY_EN
                S_PARITY: begin
                    if (w_tick) begin
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_tick) begin
                        if (r_stop == STOP_LAST)
                            r_state <= S_IDLE;
                        else
                            r_stop <= r_stop + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx        = r_tx;
    assign full      = r_full;
    assign empty     = r_empty;
    assign level     = r_level;
    assign busy      = (r_state != S_IDLE);
    assign overflow  = r_overflow;
    assign baud_tick = w_tick;

endmodule

// File: tb/tb_uart_stream_tx.sv
// Scoreboard bench for uart_stream_tx: stimulus pushes expected words, a
// line monitor decodes frames from tx and pops/compares them.
module tb_uart_stream_tx;
    localparam int DIV = 10;
`ifdef UART_STREAM_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FRAME = (1 + 8 + PB + 1) * DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data = '0;
    logic       write = 1'b0;
    logic       cts = 1'b0;
    logic       tx, full, empty, busy, overflow, baud_tick;
    logic [2:0] level;

    uart_stream_tx #(
        .FREQUENCY (1_000_000),
        .BAUD_RATE (100_000),
        .DATA_BITS (8),
        .STOP_BITS (1),
        .FIFO_DEPTH(4)
`ifdef UART_STREAM_PARITY_EN
        ,
        .PARITY_ODD(1'b0)
`endif
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data     (data),
        .write    (write),
        .cts      (cts),
        .tx       (tx),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .busy     (busy),
        .overflow (overflow),
        .baud_tick(baud_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   ticks    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Count baud ticks mid-cycle, clear of both clock edges.
    always @(posedge clk) begin
        #2;
        if (baud_tick === 1'b1) ticks++;
    end

    // Line monitor: decode each frame mid-bit and compare with the scoreboard.
    initial begin : monitor
        logic       tx_prev;
        logic       abort;
        logic       st_ok, sp_ok, par;
        logic [7:0] bits;
        exp_t       e;
        tx_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset && tx_prev && tx === 1'b0) begin
                abort = 1'b0;
                par   = 1'b0;
                repeat (DIV/2) begin @(negedge clk); if (reset) abort = 1'b1; end
                st_ok = (tx === 1'b0);
                for (int b = 0; b < 8 + PB; b++) begin
                    repeat (DIV) begin @(negedge clk); if (reset) abort = 1'b1; end
                    if (b < 8) bits[b] = tx;
                    else par = tx;
                end
                repeat (DIV) begin @(negedge clk); if (reset) abort = 1'b1; end
                sp_ok = (tx === 1'b1);
                if (!abort) begin
                    if (q.size() == 0) begin
                        chk("unexpected_frame", {24'd0, bits}, 32'hFFFF_FFFF);
                    end else begin
                        e = q.pop_front();
                        chk("frame_data", {24'd0, bits}, {24'd0, e.d});
                        chk("start_bit_low", {31'd0, st_ok}, 32'd1);
                        chk("stop_bit_high", {31'd0, sp_ok}, 32'd1);
                        if (PB == 1) chk("parity_bit", {31'd0, par}, {31'd0, e.p});
                    end
                end
            end
            tx_prev = tx;
        end
    end

    task automatic wait_busy(input logic v, input string nm);
        int n = 0;
        while (busy !== v && n < 2000) begin @(negedge clk); n++; end
        if (busy !== v) chk(nm, {31'd0, busy}, {31'd0, v});
    endtask

    task automatic wait_txlow(input string nm);
        int n = 0;
        while (tx !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        if (tx !== 1'b0) chk(nm, {31'd0, tx}, 32'd0);
    endtask

    task automatic put(input logic [7:0] d);
        @(negedge clk);
        data  = d;
        write = 1'b1;
    endtask

    initial begin : stim
        int n;
        int t0;
        int bad;

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_baud_tick", {31'd0, baud_tick}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        cts = 1'b1;

        // Single byte 0x4A: latency and frame length.
        put(8'h4A); q.push_back('{8'h4A, 1'b1});
        @(negedge clk); write = 1'b0;
        chk("lat_level_n1", {29'd0, level}, 32'd1);
        chk("lat_empty_n1", {31'd0, empty}, 32'd0);
        chk("lat_tx_high_n1", {31'd0, tx}, 32'd1);
        @(negedge clk);
        chk("lat_tx_low_n2", {31'd0, tx}, 32'd0);
        n = 0;
        while (busy === 1'b1 && n < 500) begin @(negedge clk); n++; end
        chk("frame_len", n, FRAME);

        // Back-to-back 0x55, 0xAA: one idle cycle, 10 ticks per frame.
        repeat (5) @(negedge clk);
        t0 = ticks;
        put(8'h55); q.push_back('{8'h55, 1'b0});
        put(8'hAA); q.push_back('{8'hAA, 1'b0});
        @(negedge clk); write = 1'b0;
        wait_busy(1'b1, "b2b_start_timeout");
        wait_busy(1'b0, "b2b_end1_timeout");
        chk("b2b_idle_tx", {31'd0, tx}, 32'd1);
        n = 0;
        while (busy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("b2b_idle_gap", n, 1);
        wait_busy(1'b0, "b2b_end2_timeout");
        chk("b2b_ticks", ticks - t0, 2 * (FRAME / DIV));

        // Flow control: drop cts in data bit 2, second word queued.
        repeat (5) @(negedge clk);
        put(8'h3C); q.push_back('{8'h3C, 1'b0});
        put(8'hC3); q.push_back('{8'hC3, 1'b0});
        @(negedge clk); write = 1'b0;
        wait_txlow("fc_start_timeout");
        repeat (33) @(negedge clk);
        cts = 1'b0;
        wait_busy(1'b0, "fc_frame_end_timeout");
        chk("fc_level_held", {29'd0, level}, 32'd1);
        bad = 0;
        repeat (30) begin @(negedge clk); if (tx !== 1'b1 || busy !== 1'b0) bad++; end
        chk("fc_quiet_while_cts_low", bad, 0);
        cts = 1'b1;
        chk("fc_tx_high_at_cts_rise", {31'd0, tx}, 32'd1);
        @(negedge clk);
        chk("fc_start_after_cts", {31'd0, tx}, 32'd0);
        wait_busy(1'b0, "fc_frame2_timeout");

        // Overflow with cts low: 5 writes, only 4 accepted.
        repeat (5) @(negedge clk);
        cts = 1'b0;
        put(8'h11); q.push_back('{8'h11, 1'b0});
        put(8'h22); q.push_back('{8'h22, 1'b0});
        put(8'h33); q.push_back('{8'h33, 1'b0});
        put(8'h44); q.push_back('{8'h44, 1'b0});
        put(8'h99);
        chk("ovf_full_before_5th", {31'd0, full}, 32'd1);
        chk("ovf_clear_before_5th", {31'd0, overflow}, 32'd0);
        @(negedge clk); write = 1'b0;
        chk("ovf_level", {29'd0, level}, 32'd4);
        chk("ovf_full", {31'd0, full}, 32'd1);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        bad = 0;
        repeat (20) begin @(negedge clk); if (tx !== 1'b1) bad++; end
        chk("ovf_tx_idle", bad, 0);
        cts = 1'b1;
        n = 0;
        while (!(empty === 1'b1 && busy === 1'b0 && q.size() == 0) && n < 2000) begin
            @(negedge clk); n++;
        end
        chk("ovf_drained", {31'd0, empty}, 32'd1);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        repeat (150) @(negedge clk);

        // Reset during data bit 4 with another word still queued.
        put(8'h5A);
        put(8'h0F);
        @(negedge clk); write = 1'b0;
        wait_txlow("rstmid_start_timeout");
        repeat (53) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rstmid_tx", {31'd0, tx}, 32'd1);
        chk("rstmid_level", {29'd0, level}, 32'd0);
        chk("rstmid_empty", {31'd0, empty}, 32'd1);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_overflow", {31'd0, overflow}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (150) begin @(negedge clk); if (tx !== 1'b1 || busy !== 1'b0) bad++; end
        chk("rstmid_no_activity", bad, 0);

`ifdef UART_STREAM_PARITY_EN
        // Parity: 0x07 has three ones, even parity bit is 1.
        put(8'h07); q.push_back('{8'h07, 1'b1});
        @(negedge clk); write = 1'b0;
        wait_txlow("par_start_timeout");
        n = 0;
        while (busy === 1'b1 && n < 500) begin @(negedge clk); n++; end
        chk("par_frame_len", n, 110);
`endif

        n = 0;
        while (q.size() != 0 && n < 500) begin @(negedge clk); n++; end
        chk("scoreboard_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
